// File: rtl/run_detect_ctrl.sv
// Windowed serial run detector: after an accepted start, samples t_in for
// win_len cycles and counts runs of RUN_LEN or more consecutive 1s.
module run_detect_ctrl #(
    parameter int RUN_LEN = 2,
    parameter int WIN_W   = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIN_W-1:0] win_len,
    input  logic             t_in,
    output logic             busy,
    output logic             det,
    output logic             done,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             ovf
);
    localparam int RC_W = $clog2(RUN_LEN + 1);
    localparam logic [RC_W-1:0] RL = RC_W'(RUN_LEN);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [RC_W-1:0]  run_cnt;
    logic [WIN_W-1:0] remaining;
    logic [RC_W-1:0]  run_nxt;
    logic             hit;

    // run_cnt saturates at RUN_LEN, so a long run produces exactly one hit
    always_comb begin
        run_nxt = '0;
        if (t_in)
            run_nxt = (run_cnt == RL) ? run_cnt : run_cnt + RC_W'(1);
        hit = t_in && (run_cnt == RL - RC_W'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            det       <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            hit_cnt   <= '0;
            run_cnt   <= '0;
            remaining <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        hit_cnt <= '0;
                        ovf     <= 1'b0;
                        run_cnt <= '0;
                        busy    <= 1'b1;
                        if (win_len != '0) begin
                            state     <= RUN;
                            remaining <= win_len;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // abort takes priority, even over the final sample
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        det       <= 1'b0;
                        run_cnt   <= '0;
                        remaining <= '0;
                    end else begin
                        run_cnt   <= run_nxt;
                        remaining <= remaining - WIN_W'(1);
                        if (hit) begin
                            if (&hit_cnt) ovf <= 1'b1;
                            else          hit_cnt <= hit_cnt + CNT_W'(1);
                        end
                        if (remaining == WIN_W'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            det   <= 1'b0;
                        end else begin
                            det <= (run_nxt == RL);
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    run_cnt <= '0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    det   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_run_detect_ctrl.sv
// Bench for run_detect_ctrl: table vectors, directed corner sequences and
// random stimulus against a sample-history reference model (CNT_W=8 and 2).
module tb_run_detect_ctrl;
    localparam int RL = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0, start = 1'b0, abort = 1'b0, t_in = 1'b0;
    logic [7:0] win_len = '0;
    logic       busy0, det0, done0, ovf0, busy1, det1, done1, ovf1;
    logic [7:0] hit0;
    logic [1:0] hit1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    run_detect_ctrl #(.RUN_LEN(RL), .WIN_W(8), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .win_len(win_len),
        .t_in(t_in), .busy(busy0), .det(det0), .done(done0), .hit_cnt(hit0), .ovf(ovf0));

    run_detect_ctrl #(.RUN_LEN(RL), .WIN_W(8), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .win_len(win_len),
        .t_in(t_in), .busy(busy1), .det(det1), .done(done1), .hit_cnt(hit1), .ovf(ovf1));

    // Reference model: keeps the samples of the current window and derives
    // everything from that history.
    bit q[$];
    bit m_active = 0, m_done = 0;
    int m_left = 0;

    function automatic int count_hits();
        int h = 0;
        for (int i = RL - 1; i < q.size(); i++) begin
            bit ok = 1;
            for (int j = 0; j < RL; j++) if (!q[i-j]) ok = 0;
            if (ok && (i == RL - 1 || !q[i-RL])) h++;
        end
        return h;
    endfunction

    function automatic bit model_det();
        if (!m_active || q.size() < RL) return 0;
        for (int j = 1; j <= RL; j++) if (!q[q.size()-j]) return 0;
        return 1;
    endfunction

    task automatic model_edge(input logic r, s, a, input logic [7:0] w, input logic t);
        if (!r) begin
            q.delete(); m_active = 0; m_done = 0; m_left = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            if (a) m_active = 0;
            else begin
                q.push_back(t);
                m_left--;
                if (m_left == 0) begin m_active = 0; m_done = 1; end
            end
        end else if (s) begin
            q.delete();
            if (w == 0) m_done = 1;
            else begin m_active = 1; m_left = int'(w); end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        int h = count_hits();
        chk("busy0", int'(busy0), int'(m_active || m_done));
        chk("det0",  int'(det0),  int'(model_det()));
        chk("done0", int'(done0), int'(m_done));
        chk("hit0",  int'(hit0),  (h > 255) ? 255 : h);
        chk("ovf0",  int'(ovf0),  int'(h > 255));
        chk("busy1", int'(busy1), int'(m_active || m_done));
        chk("det1",  int'(det1),  int'(model_det()));
        chk("done1", int'(done1), int'(m_done));
        chk("hit1",  int'(hit1),  (h > 3) ? 3 : h);
        chk("ovf1",  int'(ovf1),  int'(h > 3));
    endtask

    task automatic step(input logic r, s, a, input logic [7:0] w, input logic t);
        rst = r; start = s; abort = a; win_len = w; t_in = t;
        @(posedge clk);
        model_edge(r, s, a, w, t);
        #1;
        check_model();
    endtask

    typedef struct {
        logic       r, s, a;
        logic [7:0] w;
        logic       t;
        logic       busy, det, done;
        logic [7:0] hit;
        logic       ovf;
    } vec_t;

    vec_t vt[14];

    initial begin
        // T1 (rows 0-9) followed by T2 (rows 10-11) and an idle pair
        vt[0]  = '{1, 1, 0, 8'd8, 0, 1, 0, 0, 8'd0, 0};
        vt[1]  = '{1, 0, 0, 8'd0, 0, 1, 0, 0, 8'd0, 0};
        vt[2]  = '{1, 0, 0, 8'd0, 1, 1, 0, 0, 8'd0, 0};
        vt[3]  = '{1, 0, 0, 8'd0, 1, 1, 1, 0, 8'd1, 0};
        vt[4]  = '{1, 0, 0, 8'd0, 1, 1, 1, 0, 8'd1, 0};
        vt[5]  = '{1, 0, 0, 8'd0, 0, 1, 0, 0, 8'd1, 0};
        vt[6]  = '{1, 0, 0, 8'd0, 1, 1, 0, 0, 8'd1, 0};
        vt[7]  = '{1, 0, 0, 8'd0, 1, 1, 1, 0, 8'd2, 0};
        vt[8]  = '{1, 0, 0, 8'd0, 0, 1, 0, 1, 8'd2, 0};
        vt[9]  = '{1, 0, 0, 8'd0, 0, 0, 0, 0, 8'd2, 0};
        vt[10] = '{1, 1, 0, 8'd0, 1, 1, 0, 1, 8'd0, 0};
        vt[11] = '{1, 0, 0, 8'd0, 1, 0, 0, 0, 8'd0, 0};
        vt[12] = '{1, 0, 1, 8'd0, 1, 0, 0, 0, 8'd0, 0};
        vt[13] = '{1, 0, 0, 8'd0, 0, 0, 0, 0, 8'd0, 0};

        // reset state
        step(0, 1, 1, 8'd5, 1);
        step(0, 0, 0, 8'd0, 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_hit",  int'(hit0),  0);

        for (int i = 0; i < 14; i++) begin
            step(vt[i].r, vt[i].s, vt[i].a, vt[i].w, vt[i].t);
            chk($sformatf("vec%0d_busy", i), int'(busy0), int'(vt[i].busy));
            chk($sformatf("vec%0d_det", i),  int'(det0),  int'(vt[i].det));
            chk($sformatf("vec%0d_done", i), int'(done0), int'(vt[i].done));
            chk($sformatf("vec%0d_hit", i),  int'(hit0),  int'(vt[i].hit));
            chk($sformatf("vec%0d_ovf", i),  int'(ovf0),  int'(vt[i].ovf));
        end

        // T3: long run counts once, det holds until DONE
        step(1, 1, 0, 8'd5, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 8'd0, 1);
            if (i == 1) chk("t3_det_after2", int'(det0), 1);
        end
        chk("t3_done", int'(done0), 1);
        chk("t3_det_done", int'(det0), 0);
        chk("t3_hit", int'(hit0), 1);
        step(1, 0, 0, 8'd0, 0);

        // T4: saturation on the CNT_W=2 instance
        step(1, 1, 0, 8'd20, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 8'd0, (i % 3) != 2);
        chk("t4_done", int'(done1), 1);
        chk("t4_hit1", int'(hit1), 3);
        chk("t4_ovf1", int'(ovf1), 1);
        chk("t4_hit0", int'(hit0), 7);
        chk("t4_ovf0", int'(ovf0), 0);
        step(1, 0, 0, 8'd0, 0);
        chk("t4_hold", int'(hit1), 3);

        // T5: start ignored in RUN, abort on 4th sample
        step(1, 1, 0, 8'd8, 0);
        step(1, 0, 0, 8'd0, 1);
        step(1, 1, 0, 8'd3, 1);
        step(1, 0, 0, 8'd0, 0);
        step(1, 0, 1, 8'd0, 1);
        chk("t5_busy", int'(busy0), 0);
        chk("t5_hit", int'(hit0), 1);
        step(1, 0, 0, 8'd0, 0);
        chk("t5_nodone", int'(done0), 0);

        // abort on the last-sample edge suppresses done
        step(1, 1, 0, 8'd2, 0);
        step(1, 0, 0, 8'd0, 1);
        step(1, 0, 1, 8'd0, 1);
        chk("abort_last_done", int'(done0), 0);

        // T6: reset mid-window, then a clean window
        step(1, 1, 0, 8'd8, 0);
        step(1, 0, 0, 8'd0, 1);
        step(1, 0, 0, 8'd0, 1);
        step(0, 0, 0, 8'd0, 1);
        chk("t6_det", int'(det0), 0);
        chk("t6_hit", int'(hit0), 0);
        step(1, 0, 0, 8'd0, 1);
        chk("t6_idle", int'(busy0), 0);
        step(1, 1, 0, 8'd2, 0);
        step(1, 0, 0, 8'd0, 1);
        step(1, 0, 0, 8'd0, 1);
        chk("t6_done", int'(done0), 1);
        chk("t6_hit2", int'(hit0), 1);

        // random stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            logic r = ($urandom_range(0, 199) != 0);
            logic s = ($urandom_range(0, 5) == 0);
            logic a = ($urandom_range(0, 24) == 0);
            logic [7:0] w = 8'($urandom_range(0, 14));
            logic t = ($urandom_range(0, 9) < 6);
            step(r, s, a, w, t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
